// File: rtl/role_axi_pkg.sv
// role_axi_pkg: shared decoupler state encoding and AXI burst/resp constants for role wrappers
package role_axi_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, DECOUPLED} dec_state_e;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
endpackage

// File: rtl/role_outstanding_ctr.sv
// role_outstanding_ctr: up/down transaction counter with full/zero flags, never drops below zero
module role_outstanding_ctr #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         zero
);
    assign full = count >= W'(MAX);
    assign zero = count == '0;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            count <= '0;
        else if (inc && !dec)
            count <= count + 1'b1;
        else if (dec && !inc && !zero)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/role_axi_decoupler.sv
// role_axi_decoupler: gates role AXI4 handshakes for partial reconfiguration,
// draining in-flight bursts before isolation and capping outstanding transactions
module role_axi_decoupler
    import role_axi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic decouple_req,
    output logic decouple_ack,
    output logic drain_timeout,
    input  logic s_awvalid,
    output logic s_awready,
    output logic m_awvalid,
    input  logic m_awready,
    input  logic s_wvalid,
    input  logic s_wlast,
    output logic s_wready,
    output logic m_wvalid,
    input  logic m_wready,
    input  logic m_bvalid,
    output logic m_bready,
    output logic s_bvalid,
    input  logic s_bready,
    input  logic s_arvalid,
    output logic s_arready,
    output logic m_arvalid,
    input  logic m_arready,
    input  logic m_rvalid,
    input  logic m_rlast,
    output logic m_rready,
    output logic s_rvalid,
    input  logic s_rready
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    dec_state_e state_q, state_d;
    logic [CNT_W-1:0] wr_out, rd_out, w_owed;
    logic [TW-1:0] tcnt_q;
    logic wr_full, wr_zero, rd_full, rd_zero, w_full, w_zero;
    logic aw_hold, ar_hold, w_mid;
    logic run, dec, idle, aw_open, ar_open, w_open;
    logic aw_hs, ar_hs, w_hs, b_hs, r_last_hs;
    logic ctr_unused;

    assign run = state_q == RUN;
    assign dec = state_q == DECOUPLED;

    // hold flags keep an already-presented valid open across DRAIN or saturation
    assign aw_open = (run && !wr_full) || aw_hold;
    assign ar_open = (run && !rd_full) || ar_hold;
    assign w_open  = run || w_mid || !w_zero;

    assign m_awvalid = s_awvalid && aw_open;
    assign s_awready = m_awready && aw_open;
    assign m_arvalid = s_arvalid && ar_open;
    assign s_arready = m_arready && ar_open;
    assign m_wvalid  = s_wvalid && w_open;
    assign s_wready  = m_wready && w_open;

    // stray responses are sunk once the role is isolated
    assign s_bvalid = m_bvalid && !dec;
    assign m_bready = s_bready || dec;
    assign s_rvalid = m_rvalid && !dec;
    assign m_rready = s_rready || dec;

    assign aw_hs     = m_awvalid && m_awready;
    assign ar_hs     = m_arvalid && m_arready;
    assign w_hs      = m_wvalid && m_wready;
    assign b_hs      = s_bvalid && s_bready;
    assign r_last_hs = s_rvalid && s_rready && m_rlast;

    assign idle = wr_zero && rd_zero && w_zero && !aw_hold && !ar_hold && !w_mid;
    assign ctr_unused = ^{wr_out, rd_out, w_owed, w_full};

    role_outstanding_ctr #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_wr_out (
        .aclk(aclk), .aresetn(aresetn), .inc(aw_hs), .dec(b_hs),
        .count(wr_out), .full(wr_full), .zero(wr_zero)
    );
    role_outstanding_ctr #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_rd_out (
        .aclk(aclk), .aresetn(aresetn), .inc(ar_hs), .dec(r_last_hs),
        .count(rd_out), .full(rd_full), .zero(rd_zero)
    );
    role_outstanding_ctr #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_w_owed (
        .aclk(aclk), .aresetn(aresetn), .inc(aw_hs), .dec(w_hs && s_wlast),
        .count(w_owed), .full(w_full), .zero(w_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       state_d = decouple_req ? DRAIN : RUN;
            DRAIN:     state_d = !decouple_req ? RUN : idle ? DECOUPLED : DRAIN;
            DECOUPLED: state_d = decouple_req ? DECOUPLED : RUN;
            default:   state_d = RUN;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= RUN;
            aw_hold       <= 1'b0;
            ar_hold       <= 1'b0;
            w_mid         <= 1'b0;
            tcnt_q        <= '0;
            drain_timeout <= 1'b0;
            decouple_ack  <= 1'b0;
        end else begin
            state_q       <= state_d;
            aw_hold       <= (m_awvalid && !m_awready) || (aw_hold && !aw_hs);
            ar_hold       <= (m_arvalid && !m_arready) || (ar_hold && !ar_hs);
            w_mid         <= w_hs ? !s_wlast : w_mid;
            tcnt_q        <= (state_q == DRAIN) ? tcnt_q + TW'(tcnt_q != TW'(TIMEOUT_CYCLES)) : '0;
            drain_timeout <= drain_timeout || (state_q == DRAIN && tcnt_q >= TW'(TIMEOUT_CYCLES - 1));
            decouple_ack  <= dec;
        end
    end
endmodule

// File: tb/tb_role_axi_decoupler.sv
// tb_role_axi_decoupler: directed plus randomized bench checked every cycle against a behavioural model
module tb_role_axi_decoupler;
    localparam int MAX = 2;
    localparam int TMO = 4096;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DEC = 2;

    logic aclk = 1'b0, aresetn = 1'b0, decouple_req = 1'b0;
    logic s_awvalid = 0, m_awready = 0, s_wvalid = 0, s_wlast = 0, m_wready = 0;
    logic m_bvalid = 0, s_bready = 0, s_arvalid = 0, m_arready = 0;
    logic m_rvalid = 0, m_rlast = 0, s_rready = 0;
    logic decouple_ack, drain_timeout, s_awready, m_awvalid, s_wready, m_wvalid;
    logic m_bready, s_bvalid, s_arready, m_arvalid, m_rready, s_rvalid;

    role_axi_decoupler #(.MAX_OUTSTANDING(MAX), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn), .decouple_req(decouple_req),
        .decouple_ack(decouple_ack), .drain_timeout(drain_timeout),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_err = 0;
    int mode, wr, rd, owed, dc;
    bit awh, arh, wmid, ack_m, tmo_m;
    bit aw_hs, ar_hs, w_hs, sb_hs, sr_hs;
    logic e_awv, e_awr, e_arv, e_arr, e_wv, e_wr, e_bv, e_br, e_rv, e_rr;
    int wbeat, wlen, b_pend, rbeat;
    int rq[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mode = M_RUN; wr = 0; rd = 0; owed = 0; dc = 0;
        awh = 0; arh = 0; wmid = 0; ack_m = 0; tmo_m = 0;
    endtask

    // one cycle: compare at negedge against the model, advance the model, return just after posedge
    task automatic tick();
        bit run, dec, idle, aw_o, ar_o, w_o;
        @(negedge aclk);
        if (!aresetn) model_reset();
        run  = mode == M_RUN;
        dec  = mode == M_DEC;
        aw_o = (run && wr < MAX) || awh;
        ar_o = (run && rd < MAX) || arh;
        w_o  = run || wmid || owed != 0;
        e_awv = s_awvalid && aw_o;  e_awr = m_awready && aw_o;
        e_arv = s_arvalid && ar_o;  e_arr = m_arready && ar_o;
        e_wv  = s_wvalid && w_o;    e_wr  = m_wready && w_o;
        e_bv  = m_bvalid && !dec;   e_br  = s_bready || dec;
        e_rv  = m_rvalid && !dec;   e_rr  = s_rready || dec;
        chk("m_awvalid", m_awvalid, e_awv);
        chk("s_awready", s_awready, e_awr);
        chk("m_arvalid", m_arvalid, e_arv);
        chk("s_arready", s_arready, e_arr);
        chk("m_wvalid", m_wvalid, e_wv);
        chk("s_wready", s_wready, e_wr);
        chk("s_bvalid", s_bvalid, e_bv);
        chk("m_bready", m_bready, e_br);
        chk("s_rvalid", s_rvalid, e_rv);
        chk("m_rready", m_rready, e_rr);
        chk("decouple_ack", decouple_ack, ack_m);
        chk("drain_timeout", drain_timeout, tmo_m);
        aw_hs = e_awv && m_awready;
        ar_hs = e_arv && m_arready;
        w_hs  = e_wv && m_wready;
        sb_hs = m_bvalid && e_br;
        sr_hs = m_rvalid && e_rr;
        if (aresetn) begin
            idle = wr == 0 && rd == 0 && owed == 0 && !awh && !arh && !wmid;
            wr   = wr + int'(aw_hs) - int'(e_bv && s_bready);
            rd   = rd + int'(ar_hs) - int'(e_rv && s_rready && m_rlast);
            owed = owed + int'(aw_hs) - int'(w_hs && s_wlast);
            if (wr < 0) wr = 0;
            if (rd < 0) rd = 0;
            if (owed < 0) owed = 0;
            awh  = aw_hs ? 1'b0 : (e_awv || awh);
            arh  = ar_hs ? 1'b0 : (e_arv || arh);
            wmid = w_hs ? !s_wlast : wmid;
            ack_m = dec;
            if (mode == M_DRAIN) begin
                if (dc < TMO) dc++;
                if (dc >= TMO) tmo_m = 1;
            end else dc = 0;
            if (mode == M_RUN) mode = decouple_req ? M_DRAIN : M_RUN;
            else if (mode == M_DRAIN) mode = !decouple_req ? M_RUN : idle ? M_DEC : M_DRAIN;
            else mode = decouple_req ? M_DEC : M_RUN;
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        model_reset();
        // reset state
        m_awready = 1;
        tick();
        #1;
        chk("rst_ack", decouple_ack, 0);
        chk("rst_timeout", drain_timeout, 0);
        chk("rst_s_awready", s_awready, 1);
        aresetn = 1;
        tick();
        // outstanding cap: third AW blocked until a B returns
        s_awvalid = 1;
        tick(); tick();
        #1;
        chk("cap_m_awvalid", m_awvalid, 0);
        chk("cap_s_awready", s_awready, 0);
        tick();
        m_bvalid = 1; s_bready = 1;
        tick();
        m_bvalid = 0;
        #1;
        chk("cap_reopen", m_awvalid, 1);
        tick();
        s_awvalid = 0;
        s_wvalid = 1; s_wlast = 1; m_wready = 1;
        repeat (3) tick();
        s_wvalid = 0;
        m_bvalid = 1;
        repeat (2) tick();
        m_bvalid = 0;
        // pending AW survives decouple request
        s_awvalid = 1; m_awready = 0;
        tick();
        decouple_req = 1;
        tick();
        #1;
        chk("hold_m_awvalid", m_awvalid, 1);
        s_arvalid = 1; m_arready = 1;
        #1;
        chk("drain_m_arvalid", m_arvalid, 0);
        chk("drain_s_arready", s_arready, 0);
        s_arvalid = 0;
        m_awready = 1;
        tick();
        s_awvalid = 0;
        s_wvalid = 1; s_wlast = 1;
        #1;
        chk("drain_s_wready", s_wready, 1);
        tick();
        s_wvalid = 0;
        m_bvalid = 1;
        tick();
        m_bvalid = 0;
        tick(); tick();
        #1;
        chk("ack_after_drain", decouple_ack, 1);
        // stray B sunk while decoupled, then release
        m_bvalid = 1; s_bready = 0;
        #1;
        chk("dec_m_bready", m_bready, 1);
        chk("dec_s_bvalid", s_bvalid, 0);
        tick();
        m_bvalid = 0; s_bready = 1; decouple_req = 0;
        tick();
        #1;
        chk("ack_lag_high", decouple_ack, 1);
        tick();
        #1;
        chk("ack_lag_low", decouple_ack, 0);
        // 4-beat write, decouple after beat 1
        s_awvalid = 1;
        tick();
        s_awvalid = 0;
        s_wvalid = 1; s_wlast = 0;
        tick();
        decouple_req = 1;
        tick();
        s_awvalid = 1;
        #1;
        chk("burst_s_awready", s_awready, 0);
        chk("burst_m_awvalid", m_awvalid, 0);
        tick();
        s_wlast = 1;
        #1;
        chk("burst_last_m_wvalid", m_wvalid, 1);
        tick();
        s_wvalid = 0; s_wlast = 0;
        m_bvalid = 1;
        #1;
        chk("burst_s_bvalid", s_bvalid, 1);
        tick();
        m_bvalid = 0;
        #1;
        chk("burst_ack_c1", decouple_ack, 0);
        tick();
        #1;
        chk("burst_ack_c2", decouple_ack, 0);
        tick();
        #1;
        chk("burst_ack_c3", decouple_ack, 1);
        s_awvalid = 0; decouple_req = 0;
        tick(); tick();
        // drain timeout with a stalled 8-beat read
        s_arvalid = 1;
        tick();
        s_arvalid = 0;
        decouple_req = 1;
        tick();
        repeat (TMO - 1) tick();
        #1;
        chk("timeout_before", drain_timeout, 0);
        tick();
        #1;
        chk("timeout_at", drain_timeout, 1);
        repeat (900) tick();
        m_rvalid = 1; s_rready = 1;
        for (int i = 0; i < 8; i++) begin
            m_rlast = i == 7;
            tick();
        end
        m_rvalid = 0; m_rlast = 0;
        tick(); tick();
        #1;
        chk("timeout_ack", decouple_ack, 1);
        chk("timeout_sticky", drain_timeout, 1);
        decouple_req = 0;
        tick();
        // reset during DRAIN with writes outstanding
        s_awvalid = 1;
        tick(); tick();
        s_awvalid = 0;
        decouple_req = 1;
        tick();
        aresetn = 0;
        #1;
        chk("mid_rst_ack", decouple_ack, 0);
        chk("mid_rst_timeout", drain_timeout, 0);
        s_awvalid = 1;
        #1;
        chk("mid_rst_s_awready", s_awready, 1);
        s_awvalid = 0; decouple_req = 0;
        m_awready = 0; m_wready = 0; s_bready = 0; m_arready = 0; s_rready = 0;
        tick();
        aresetn = 1;
        tick();
        // randomized traffic with AXI-compliant role and shell
        wbeat = 0; wlen = 1; b_pend = 0; rbeat = 0; rq.delete();
        for (int c = 0; c < 6000; c++) begin
            if (w_hs) begin
                if (s_wlast) begin wbeat = 0; b_pend++; end
                else wbeat++;
            end
            if (sb_hs) b_pend--;
            if (sr_hs) begin
                if (m_rlast) begin void'(rq.pop_front()); rbeat = 0; end
                else rbeat++;
            end
            if (ar_hs) rq.push_back($urandom_range(1, 4));
            if ($urandom_range(0, 199) == 0) decouple_req = !decouple_req;
            if (!(s_awvalid && !aw_hs)) s_awvalid = $urandom_range(0, 2) == 0;
            if (!(s_arvalid && !ar_hs)) s_arvalid = $urandom_range(0, 2) == 0;
            if (!(s_wvalid && !w_hs)) begin
                if ((owed > 0 || wmid) && $urandom_range(0, 1) == 1) begin
                    if (wbeat == 0) wlen = $urandom_range(1, 4);
                    s_wvalid = 1;
                    s_wlast = wbeat == wlen - 1;
                end else begin
                    s_wvalid = 0; s_wlast = 0;
                end
            end
            if (!(m_bvalid && !sb_hs)) m_bvalid = b_pend > 0 && $urandom_range(0, 1) == 1;
            if (!(m_rvalid && !sr_hs)) begin
                if (rq.size() > 0 && $urandom_range(0, 1) == 1) begin
                    m_rvalid = 1;
                    m_rlast = rbeat == rq[0] - 1;
                end else begin
                    m_rvalid = 0; m_rlast = 0;
                end
            end
            m_awready = $urandom_range(0, 1) == 1;
            m_arready = $urandom_range(0, 1) == 1;
            m_wready  = $urandom_range(0, 1) == 1;
            s_bready  = $urandom_range(0, 1) == 1;
            s_rready  = $urandom_range(0, 1) == 1;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
